// File: rtl/timer_pkg.sv
// Shared command codes and FSM state type for the timer controller.
// Included by the interface, prescaler and top-level files.
package timer_pkg;

   localparam logic [2:0] TIM_ENABLE  = 3'b000;
   localparam logic [2:0] TIM_PSC_I   = 3'b001;
   localparam logic [2:0] TIM_ARR_I   = 3'b010;
   localparam logic [2:0] TIM_PSC_REG = 3'b100;
   localparam logic [2:0] TIM_ARR_REG = 3'b101;
   localparam logic [2:0] TIM_DISABLE = 3'b111;

   typedef enum logic [1:0] {
      STOPPED,
      LOAD,
      RUN
   } tim_state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Timer command channel: valid/ready handshake carrying funct3 and operand.
// Master drives the command; slave returns cmd_ready.
interface timer_ctrl_if;

   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [31:0] cmd_data;
   logic        cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..psc_active while run is high, tick on the terminal count.
// Zero latency on tick (combinational from psc_cnt); clear has priority over run.
module timer_prescaler #(
   parameter int PSC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 clear,
   input  logic [PSC_WIDTH-1:0] psc_active,
   output logic                 tick
);

   logic [PSC_WIDTH-1:0] psc_cnt;
   logic                 at_top;

   assign at_top = (psc_cnt == psc_active);
   assign tick   = run && at_top;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         psc_cnt <= '0;
      end else if (clear) begin
         psc_cnt <= '0;
      end else if (run) begin
         psc_cnt <= at_top ? '0 : psc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Up-counting timer with preloaded PSC/ARR, update pulse and sticky irq on wrap.
// Commands accepted in one cycle except during the single LOAD cycle (cmd_ready low).
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int PSC_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   timer_ctrl_if.slave      bus,
   input  logic             irq_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             running,
   output logic             update_evt,
   output logic             irq_flag
);

   tim_state_t           state;
   tim_state_t           state_nxt;
   logic                 cmd_fire;
   logic                 load;
   logic                 tick;
   logic                 wrap;
   logic [PSC_WIDTH-1:0] psc_shadow;
   logic [PSC_WIDTH-1:0] psc_active;
   logic [WIDTH-1:0]     arr_shadow;
   logic [WIDTH-1:0]     arr_active;

   assign bus.cmd_ready = (state != LOAD);
   assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
   assign wrap          = tick && (cnt == arr_active);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= STOPPED;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      running   = 1'b0;
      load      = 1'b0;
      case (state)
         STOPPED: begin
            if (cmd_fire && bus.cmd_op == TIM_ENABLE) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            running = 1'b1;
            if (cmd_fire && bus.cmd_op == TIM_DISABLE) begin
               state_nxt = STOPPED;
            end
         end
         default: state_nxt = STOPPED;
      endcase
   end

   timer_prescaler #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_prescaler (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (running),
      .clear      (load),
      .psc_active (psc_active),
      .tick       (tick)
   );

   // Shadow registers take writes in any state; they only reach the counter at LOAD or wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         psc_shadow <= '0;
         arr_shadow <= '1;
      end else if (cmd_fire) begin
         case (bus.cmd_op)
            TIM_PSC_I, TIM_PSC_REG: psc_shadow <= bus.cmd_data[PSC_WIDTH-1:0];
            TIM_ARR_I, TIM_ARR_REG: arr_shadow <= bus.cmd_data[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt        <= '0;
         psc_active <= '0;
         arr_active <= '1;
         update_evt <= 1'b0;
         irq_flag   <= 1'b0;
      end else begin
         update_evt <= wrap;
         if (wrap) begin
            irq_flag <= 1'b1;
         end else if (irq_clr) begin
            irq_flag <= 1'b0;
         end

         if (load || wrap) begin
            psc_active <= psc_shadow;
            arr_active <= arr_shadow;
            cnt        <= '0;
         end else if (tick) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Table-driven and hand-sequenced checks of timer_ctrl against a closed-form period model.
module tb_timer_ctrl;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        irq_clr;
   logic [31:0] cnt;
   logic        running;
   logic        update_evt;
   logic        irq_flag;

   timer_ctrl_if bus_if ();

   timer_ctrl #(
      .WIDTH     (32),
      .PSC_WIDTH (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus_if),
      .irq_clr    (irq_clr),
      .cnt        (cnt),
      .running    (running),
      .update_evt (update_evt),
      .irq_flag   (irq_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] cnt;
      logic        upd;
      logic        run;
      logic        irq;
      logic        rdy;
   } exp_t;

   typedef struct {
      int         psc;
      int         arr;
      int         ncyc;
      int         exp_period;
      int         exp_pulses;
      int         cmd_k;
      logic [2:0] cmd_op;
      bit         use_reg;
   } vec_t;

   exp_t sb[$];
   int   upd_k[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Expected outputs k cycles after RUN entry, from the period formula.
   function automatic exp_t model(input longint psc, input longint arr, input int k);
      exp_t   m;
      longint per;
      per   = (psc + 1) * (arr + 1);
      m.cnt = 32'((longint'(k) / (psc + 1)) % (arr + 1));
      m.upd = (k > 0) && ((longint'(k) % per) == 0);
      m.run = 1'b1;
      m.irq = (longint'(k) >= per);
      m.rdy = 1'b1;
      return m;
   endfunction

   function automatic exp_t mk(input logic [31:0] c, input logic u, input logic r,
                               input logic i, input logic y);
      exp_t m;
      m.cnt = c; m.upd = u; m.run = r; m.irq = i; m.rdy = y;
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic check_pop(input string name);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty at time %0t", name, $time);
      end else begin
         e = sb.pop_front();
         if ({cnt, update_evt, running, irq_flag, bus_if.cmd_ready} !==
             {e.cnt, e.upd, e.run, e.irq, e.rdy}) begin
            n_fail++;
            $display("FAIL %s @%0t: got cnt=%0d upd=%b run=%b irq=%b rdy=%b, expected cnt=%0d upd=%b run=%b irq=%b rdy=%b",
                     name, $time, cnt, update_evt, running, irq_flag, bus_if.cmd_ready,
                     e.cnt, e.upd, e.run, e.irq, e.rdy);
         end
      end
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      irq_clr          = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 3'b000;
      bus_if.cmd_data  = 32'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] data);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = op;
      bus_if.cmd_data  = data;
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
   endtask

   // Leaves the bench at the first observation in RUN (k = 0).
   task automatic enable_seq(input string name);
      send(TIM_ENABLE, 32'd0);
      check({name, "_load_rdy"}, 32'(bus_if.cmd_ready), 32'd0);
      check({name, "_load_run"}, 32'(running), 32'd0);
      @(negedge clk);
   endtask

   task automatic start(input int psc, input int arr, input bit use_reg, input string name);
      send(use_reg ? TIM_PSC_REG : TIM_PSC_I, 32'(psc));
      send(use_reg ? TIM_ARR_REG : TIM_ARR_I, 32'(arr));
      enable_seq(name);
   endtask

   task automatic run_loop(input int n, input int cmd_k, input logic [2:0] op,
                           input logic [31:0] data, input int clr_k, input int clr_len,
                           input int rst_k, input string name);
      upd_k.delete();
      for (int k = 0; k < n; k++) begin
         check_pop(name);
         if (update_evt) upd_k.push_back(k);
         bus_if.cmd_valid = (k == cmd_k);
         bus_if.cmd_op    = op;
         bus_if.cmd_data  = data;
         irq_clr          = (k >= clr_k) && (k < clr_k + clr_len);
         reset_n          = (k != rst_k);
         @(negedge clk);
      end
      bus_if.cmd_valid = 1'b0;
      irq_clr          = 1'b0;
      reset_n          = 1'b1;
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{0, 3, 20, 4, 4, -1, TIM_ENABLE, 1'b0};
      vecs[1] = '{2, 1, 30, 6, 4, 10, TIM_ENABLE, 1'b1};
      vecs[2] = '{0, 0,  8, 1, 7,  3, 3'b011,     1'b0};
      vecs[3] = '{1, 2, 24, 6, 3,  5, 3'b110,     1'b1};

      @(negedge clk);
      do_reset();
      check("rst_cnt", cnt, 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_irq", 32'(irq_flag), 32'd0);
      check("rst_upd", 32'(update_evt), 32'd0);
      check("rst_rdy", 32'(bus_if.cmd_ready), 32'd1);

      foreach (vecs[i]) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         do_reset();
         start(vecs[i].psc, vecs[i].arr, vecs[i].use_reg, nm);
         for (int k = 0; k < vecs[i].ncyc; k++)
            sb.push_back(model(vecs[i].psc, vecs[i].arr, k));
         run_loop(vecs[i].ncyc, vecs[i].cmd_k, vecs[i].cmd_op, 32'd0, -1, 0, -1, nm);
         check({nm, "_pulses"}, 32'(upd_k.size()), 32'(vecs[i].exp_pulses));
         if (upd_k.size() > 0)
            check({nm, "_first_upd"}, 32'(upd_k[0]), 32'(vecs[i].exp_period));
         for (int j = 1; j < upd_k.size(); j++)
            check({nm, "_period"}, 32'(upd_k[j] - upd_k[j-1]), 32'(vecs[i].exp_period));
      end

      // ARR rewrite mid-period, then a second rewrite landing on the wrap edge.
      do_reset();
      start(0, 3, 1'b0, "preload");
      for (int k = 0; k < 26; k++) begin
         if (k < 4)       sb.push_back(mk(32'(k), 1'b0, 1'b1, 1'b0, 1'b1));
         else if (k < 20) sb.push_back(mk(32'((k - 4) % 8), ((k - 4) % 8) == 0, 1'b1, 1'b1, 1'b1));
         else             sb.push_back(mk(32'((k - 20) % 3), ((k - 20) % 3) == 0, 1'b1, 1'b1, 1'b1));
      end
      run_loop(11, 1, TIM_ARR_REG, 32'd7, -1, 0, -1, "preload_a");
      run_loop(15, 0, TIM_ARR_I, 32'd2, -1, 0, -1, "preload_b");

      // DISABLE on a non-tick cycle freezes cnt at 2; re-ENABLE clears through LOAD.
      do_reset();
      start(2, 7, 1'b1, "disable");
      for (int k = 0; k < 7; k++) sb.push_back(model(2, 7, k));
      for (int k = 7; k < 17; k++) sb.push_back(mk(32'd2, 1'b0, 1'b0, 1'b0, 1'b1));
      run_loop(17, 6, TIM_DISABLE, 32'd0, -1, 0, -1, "disable");
      send(TIM_ENABLE, 32'd0);
      check("reen_load_cnt", cnt, 32'd2);
      check("reen_load_rdy", 32'(bus_if.cmd_ready), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 6; k++) sb.push_back(model(2, 7, k));
      run_loop(6, -1, TIM_ENABLE, 32'd0, -1, 0, -1, "reenable");

      // irq_clr coincident with a wrap loses; alone it clears.
      do_reset();
      start(0, 3, 1'b0, "irq");
      for (int k = 0; k < 10; k++)
         sb.push_back(mk(32'(k % 4), (k > 0) && (k % 4 == 0), 1'b1,
                         (k == 4) || (k >= 8), 1'b1));
      run_loop(10, -1, TIM_ENABLE, 32'd0, 3, 2, -1, "irq_clr");

      // Reset mid-RUN at cnt=5, then ENABLE with reset shadows (PSC 0, ARR all-ones).
      do_reset();
      start(0, 7, 1'b0, "midrst");
      for (int k = 0; k < 6; k++) sb.push_back(model(0, 7, k));
      run_loop(6, -1, TIM_ENABLE, 32'd0, -1, 0, 5, "midrst_run");
      sb.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      check_pop("midrst_after");
      enable_seq("postrst");
      for (int k = 0; k < 12; k++) sb.push_back(model(0, 64'hffff_ffff, k));
      run_loop(12, -1, TIM_ENABLE, 32'd0, -1, 0, -1, "postrst_arr");

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Timer peripheral controller driven by the TIMER opcode group (0100101) decoded in the control unit.
- Accepts timer commands (funct3 plus operand) through a valid/ready handshake and keeps preloaded prescaler (PSC) and auto-reload (ARR) registers.
- Sequences an up-counting timer and raises an update event and a sticky interrupt flag on each counter wrap.
- Sits beside the ALU/regfile; the operand comes from the ALU result (immediate or register form).

Parameters:
- WIDTH, 32: counter and ARR width.
- PSC_WIDTH, 16: prescaler width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  timer command present (cu timer_en path)
- cmd_op  in  3  command code (funct3)
- cmd_data  in  32  operand (ALU result)
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- irq_clr  in  1  clears irq_flag
- cnt  out  WIDTH  current counter value
- running  out  1  high in RUN state
- update_evt  out  1  one-cycle pulse on counter wrap
- irq_flag  out  1  sticky, set on wrap

Behaviour:
- Clock/reset: one clock, clk; reset_n is synchronous and active-low.
- Reset values: state STOPPED; cnt=0; psc_cnt=0; running=0; update_evt=0; irq_flag=0; cmd_ready=1; psc_shadow=0; arr_shadow=all-ones; psc_active=0; arr_active=all-ones.
- Reset mid-operation: reset_n low on any clock edge forces all reset values, regardless of state or pending command.
- Commands, acted on only at handshake:
  - 000 ENABLE
  - 001/100 PSC write: psc_shadow <= cmd_data[PSC_WIDTH-1:0]
  - 010/101 ARR write: arr_shadow <= cmd_data[WIDTH-1:0]
  - 111 DISABLE
  - Any other code is accepted with no effect.
- States: STOPPED, LOAD, RUN.
- STOPPED:
  - cnt and psc_cnt hold their values.
  - ENABLE -> LOAD.
  - DISABLE: no effect.
- LOAD (exactly 1 cycle):
  - cmd_ready=0.
  - psc_active <= psc_shadow; arr_active <= arr_shadow; psc_cnt <= 0; cnt <= 0.
  - Next state RUN.
- RUN:
  - running=1.
  - Every clk: if psc_cnt==psc_active then psc_cnt<=0 and tick=1, else psc_cnt+1.
  - On tick: if cnt==arr_active, then cnt<=0, update_evt<=1 (next cycle, coincident with cnt showing 0), irq_flag<=1, psc_active<=psc_shadow, arr_active<=arr_shadow. Otherwise cnt<=cnt+1.
  - Resulting period is (PSC+1)*(ARR+1) clocks.
  - DISABLE -> STOPPED next cycle, counters frozen; the DISABLE cycle itself still counts.
  - ENABLE in RUN: no effect, no restart.
- cmd_ready = (state != LOAD), combinational.
- Preload: PSC/ARR writes while in RUN change shadow only and take effect at the next wrap. If a write coincides with a wrap, the active registers take the pre-write shadow, and the new value applies at the following wrap.
- ARR=0: wrap on every tick. PSC=0: tick every clock. PSC=0 with ARR=0 gives update_evt high continuously.
- irq_clr and a wrap in the same cycle: set wins.
- No overflow is possible: cnt never exceeds arr_active because active changes only at wrap, when cnt is 0.

Decomposition:
- Package timer_pkg holds:
  - localparams TIM_ENABLE=3'b000, TIM_PSC_I=3'b001, TIM_ARR_I=3'b010, TIM_PSC_REG=3'b100, TIM_ARR_REG=3'b101, TIM_DISABLE=3'b111
  - typedef enum logic [1:0] {STOPPED, LOAD, RUN} tim_state_t
- One sub-module, timer_prescaler:
  - Contains psc_cnt, the compare against psc_active, and the tick output.
  - Inputs: clk, reset_n, run, clear.
- The FSM, shadow/active registers, main counter and flags live in timer_ctrl.

Test Plan:
1. Reset with reset_n=0 for 2 cycles, then check all outputs and cmd_ready -> cnt=0, running=0, irq_flag=0, update_evt=0, cmd_ready=1.
2. PSC write 0, ARR write 3, then ENABLE at cycle T -> cmd_ready=0 at T+1, running=1 from T+2. cnt reads 0,1,2,3 at T+2..T+5. cnt=0 with update_evt=1 at T+6 and every 4 cycles after; irq_flag set at T+6.
3. PSC=2, ARR=1, ENABLE -> cnt increments every 3 clocks; update_evt period is 6 clocks.
4. In RUN with ARR=3, write ARR=7 mid-period -> current period ends after 4 counts; subsequent periods are 8 counts.
5. Issue DISABLE in RUN when cnt=2 -> running=0 next cycle and cnt holds 2 for 10 cycles. A later ENABLE -> LOAD clears cnt to 0.
6. Assert irq_clr on the same cycle as a wrap -> irq_flag stays 1. irq_clr alone on the next cycle -> irq_flag=0.
7. Assert reset_n=0 mid-RUN with cnt=5 -> next cycle state STOPPED, cnt=0, ARR active reset to all-ones.
